// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// Holds the requester count, the requester-index type and the FSM state enum.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef logic [IDX_W-1:0] req_idx_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_RD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin selector (purely combinational).
// Ports: i_elig  - eligible requester mask
//        i_last  - index of the most recently granted requester
//        o_gnt   - one-hot winner (all zero when nobody is eligible)
//        o_idx   - winner index (0 when nobody is eligible)
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_elig,
    input  req_idx_t           i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output req_idx_t           o_idx
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        case (i_elig)
            2'b01: begin
                o_gnt = 2'b01;
                o_idx = 1'b0;
            end
            2'b10: begin
                o_gnt = 2'b10;
                o_idx = 1'b1;
            end
            2'b11: begin
                // Tie: the one not granted most recently wins.
                o_idx = ~i_last;
                o_gnt = i_last ? 2'b01 : 2'b10;
            end
            default: begin
                o_gnt = '0;
                o_idx = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between two requesters with
// round-robin arbitration; reads block further grants until they complete.
// Ports: clk_a/arst_aq clock and async active-high reset;
//        req_en/we/addr/din requester commands; req_gnt grant pulses;
//        req_valid/dout/err read response; m_en/we/addr/din memory command;
//        m_dout/m_valid memory read response.
// Option: define MEM_ARB_TIMEOUT_EN to build the read watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                                 clk_a,
    input  logic                                 arst_aq,
    input  logic [NUM_REQ-1:0]                   req_en,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_din,
    output logic [NUM_REQ-1:0]                   req_gnt,
    output logic [NUM_REQ-1:0]                   req_valid,
    output logic [DATA_WIDTH-1:0]                req_dout,
    output logic [NUM_REQ-1:0]                   req_err,
    output logic                                 m_en,
    output logic                                 m_we,
    output logic [ADDR_WIDTH-1:0]                m_addr,
    output logic [DATA_WIDTH-1:0]                m_din,
    input  logic [DATA_WIDTH-1:0]                m_dout,
    input  logic                                 m_valid
);

    arb_state_t              r_state;
    req_idx_t                r_last;
    req_idx_t                r_owner;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [NUM_REQ-1:0]      r_valid;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_m_en;
    logic                    r_m_we;
    logic [ADDR_WIDTH-1:0]   r_m_addr;
    logic [DATA_WIDTH-1:0]   r_m_din;

    logic [NUM_REQ-1:0]      w_elig;
    logic [NUM_REQ-1:0]      w_pick;
    req_idx_t                w_idx;
    logic                    w_any;

    // A requester granted this cycle still holds req_en; mask it so the
    // same command is not accepted twice.
    assign w_elig = req_en & ~r_gnt;
    assign w_any  = |w_elig;

    rr_pick2 u_pick (
        .i_elig (w_elig),
        .i_last (r_last),
        .o_gnt  (w_pick),
        .o_idx  (w_idx)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_REQ-1:0]      r_err;
    assign req_err = r_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYC;
    assign req_err      = '0;
`endif

    always_ff @(posedge clk_a or posedge arst_aq) begin
        if (arst_aq) begin
            r_state  <= ST_IDLE;
            r_last   <= 1'b1;
            r_owner  <= '0;
            r_gnt    <= '0;
            r_valid  <= '0;
            r_dout   <= '0;
            r_m_en   <= 1'b0;
            r_m_we   <= 1'b0;
            r_m_addr <= '0;
            r_m_din  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= '0;
`endif
        end else begin
            // Command and response outputs are single-cycle pulses.
            r_gnt    <= '0;
            r_valid  <= '0;
            r_dout   <= '0;
            r_m_en   <= 1'b0;
            r_m_we   <= 1'b0;
            r_m_addr <= '0;
            r_m_din  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_err    <= '0;
`endif
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt    <= w_pick;
                        r_last   <= w_idx;
                        r_m_en   <= 1'b1;
                        r_m_we   <= req_we[w_idx];
                        r_m_addr <= req_addr[w_idx];
                        r_m_din  <= req_din[w_idx];
                        if (!req_we[w_idx]) begin
                            r_state <= ST_WAIT_RD;
                            r_owner <= w_idx;
`ifdef MEM_ARB_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end
                end
                ST_WAIT_RD: begin
                    // m_valid takes priority over an expiring watchdog.
                    if (m_valid) begin
                        r_valid[r_owner] <= 1'b1;
                        r_dout           <= m_dout;
                        r_state          <= ST_IDLE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYC)) begin
                        r_valid[r_owner] <= 1'b1;
                        r_err[r_owner]   <= 1'b1;
                        r_state          <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    assign req_gnt   = r_gnt;
    assign req_valid = r_valid;
    assign req_dout  = r_dout;
    assign m_en      = r_m_en;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_din     = r_m_din;

endmodule
